// File: rtl/serial_adder_sub.sv
// Digit-serial two's-complement adder/subtractor: WIDTH bits, CHUNK bits per clock, LSB chunk first.
// Optional ADDSUB_SAT_EN: saturate s_out to signed max/min on signed overflow.
module serial_adder_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock_in,
  input  logic             reset_n_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             op_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s_out,
  output logic             cb_out,
  output logic             ov_out,
  output logic             z_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("serial_adder_sub: WIDTH must be a multiple of CHUNK");
  end

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;   // B already inverted for subtraction

  int               base;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] s_final;
  logic             ov_next;
  logic             accept;

  assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // NOTE: every always_comb output gets a default assignment first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    base      = int'(cnt) * CHUNK;
    chunk_sum = {1'b0, a_reg[base +: CHUNK]} + {1'b0, b_reg[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    s_next    = s_out;
    s_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    // Only meaningful on the last chunk, when s_next holds the complete sum.
    ov_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (s_next[WIDTH-1] != a_reg[WIDTH-1]);
    s_final   = s_next;
`ifdef ADDSUB_SAT_EN
    if (ov_next) begin
      s_final = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: operand registers are reset too; they are few flops and a clean reset keeps s_out deterministic.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_out     <= '0;
      cb_out    <= 1'b0;
      ov_out    <= 1'b0;
      z_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_reg <= a_in;
            b_reg <= b_in ^ {WIDTH{op_in}};
            carry <= op_in;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry <= chunk_sum[CHUNK];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            s_out     <= s_final;
            cb_out    <= chunk_sum[CHUNK];
            ov_out    <= ov_next;
            z_out     <= ~|s_final;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            s_out <= s_next;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              a_reg <= a_in;
              b_reg <= b_in ^ {WIDTH{op_in}};
              carry <= op_in;
              cnt   <= '0;
              state <= ST_RUN;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
